// File: rtl/ycbcr422_to_rgb565_pkg.sv
// ycbcr_pkg: constants, types and helpers for the YCbCr 4:2:2 -> RGB565 path.
// Coefficients are full-range BT.601 scaled by 256.
package ycbcr_pkg;

    localparam int K_RCR      = 359;
    localparam int K_GCB      = 88;
    localparam int K_GCR      = 183;
    localparam int K_BCB      = 454;
    localparam int CHROMA_OFS = 128;
    localparam int PIPE_LAT   = 4;

    typedef logic signed [18:0] sum_t;

    typedef enum logic {
        C0 = 1'b0,
        C1 = 1'b1
    } phase_e;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic       de;
        logic       hs;
        logic       vs;
    } pix_t;

    // Scale back by 256 and saturate to 0..255.
    function automatic logic [7:0] clamp8(input sum_t s);
        sum_t t;
        t = s >>> 8;
        if (t[18]) return 8'h00;
        if (|t[17:8]) return 8'hFF;
        return t[7:0];
    endfunction

endpackage

// File: rtl/ycbcr422_to_rgb565_if.sv
// Video stream bundle: de/hsync/vsync plus a 16-bit pixel word.
// The master drives the stream, the slave samples it.
interface ycbcr422_to_rgb565_if;

    logic        de;
    logic        hsync;
    logic        vsync;
    logic [15:0] data;

    modport master (output de, output hsync, output vsync, output data);
    modport slave  (input de, input hsync, input vsync, input data);

endinterface

// File: rtl/ycbcr422_to_rgb565_unpack.sv
// ycbcr422_unpack: chroma phase tracking and Cb/Cr re-pairing (stage 1).
// A C0 pixel borrows the C1 chroma from the live input; the C1 pixel reuses the latched pair.
module ycbcr422_unpack
    import ycbcr_pkg::*;
#(
    parameter int CB_FIRST  = 1,
    parameter int NEUTRAL_C = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [15:0] data_i,
    output pix_t        pix_o
);

    phase_e     phase_q;
    phase_e     phase_d;
    phase_e     pix_ph_q;
    logic [7:0] y_q;
    logic [7:0] c_q;
    logic       de_q;
    logic       hs_q;
    logic       vs_q;
    logic [7:0] pc0_q;
    logic [7:0] pc1_q;
    logic       in_c1;
    logic       pair;
    logic [7:0] c0;
    logic [7:0] c1;

    assign in_c1 = de_i && (phase_q == C1);
    assign pair  = de_q && (pix_ph_q == C0) && in_c1;

    // Phase alternates on every valid pixel; any de gap restarts at C0.
    always_comb begin
        phase_d = C0;
        if (de_i) phase_d = (phase_q == C0) ? C1 : C0;
    end

    // Phase FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= C0;
        else        phase_q <= phase_d;
    end

    // Stage-1 input register, tagged with the chroma phase of the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q      <= '0;
            c_q      <= '0;
            de_q     <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            pix_ph_q <= C0;
        end else begin
            y_q      <= data_i[15:8];
            c_q      <= data_i[7:0];
            de_q     <= de_i;
            hs_q     <= hsync_i;
            vs_q     <= vsync_i;
            pix_ph_q <= phase_q;
        end
    end

    // Hold the completed chroma pair for the following C1 pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc0_q <= '0;
            pc1_q <= '0;
        end else if (pair) begin
            pc0_q <= c_q;
            pc1_q <= data_i[7:0];
        end
    end

    // Select the chroma pair for the registered pixel and map C0/C1 to Cb/Cr.
    always_comb begin
        c0 = pc0_q;
        c1 = pc1_q;
        if (de_q && (pix_ph_q == C0)) begin
            c0 = c_q;
            c1 = in_c1 ? data_i[7:0] : 8'(NEUTRAL_C);
        end
        pix_o.y  = y_q;
        pix_o.cb = (CB_FIRST != 0) ? c0 : c1;
        pix_o.cr = (CB_FIRST != 0) ? c1 : c0;
        pix_o.de = de_q;
        pix_o.hs = hs_q;
        pix_o.vs = vs_q;
    end

endmodule

// File: rtl/ycbcr422_to_rgb565.sv
// ycbcr422_to_rgb565: YCbCr 4:2:2 stream to RGB565 with a fixed 4-clock latency.
// Define YCBCR2RGB_ROUND_EN to round to nearest instead of truncating the >>>8.
module ycbcr422_to_rgb565
    import ycbcr_pkg::*;
#(
    parameter int CB_FIRST  = 1,
    parameter int NEUTRAL_C = 128
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ycbcr422_to_rgb565_if.slave         ycbcr_i,
    ycbcr422_to_rgb565_if.master        rgb_o
);

    localparam sum_t KRCR = sum_t'(K_RCR);
    localparam sum_t KGCB = sum_t'(K_GCB);
    localparam sum_t KGCR = sum_t'(K_GCR);
    localparam sum_t KBCB = sum_t'(K_BCB);
    localparam int   SD   = PIPE_LAT - 1;

`ifdef YCBCR2RGB_ROUND_EN
    localparam sum_t RND = sum_t'(128);
`else
    localparam sum_t RND = sum_t'(0);
`endif

    pix_t              pix;
    logic signed [8:0] cb_s;
    logic signed [8:0] cr_s;
    sum_t              ys_d;
    sum_t              rcr_d;
    sum_t              gcb_d;
    sum_t              gcr_d;
    sum_t              bcb_d;
    sum_t              ys_q;
    sum_t              rcr_q;
    sum_t              gcb_q;
    sum_t              gcr_q;
    sum_t              bcb_q;
    logic [7:0]        r_q;
    logic [7:0]        g_q;
    logic [7:0]        b_q;
    logic [15:0]       rgb_q;
    logic [2:0]        sync_q [SD];

    ycbcr422_unpack #(
        .CB_FIRST  (CB_FIRST),
        .NEUTRAL_C (NEUTRAL_C)
    ) u_unpack (
        .clk     (clk),
        .rst_n   (rst_n),
        .de_i    (ycbcr_i.de),
        .hsync_i (ycbcr_i.hsync),
        .vsync_i (ycbcr_i.vsync),
        .data_i  (ycbcr_i.data),
        .pix_o   (pix)
    );

    assign cb_s = $signed({1'b0, pix.cb}) - 9'(CHROMA_OFS);
    assign cr_s = $signed({1'b0, pix.cr}) - 9'(CHROMA_OFS);

    // Signed products for the three colour equations.
    always_comb begin
        ys_d  = sum_t'({3'b000, pix.y, 8'h00});
        rcr_d = sum_t'(cr_s) * KRCR;
        gcb_d = sum_t'(cb_s) * KGCB;
        gcr_d = sum_t'(cr_s) * KGCR;
        bcb_d = sum_t'(cb_s) * KBCB;
    end

    // Stage 2: register products for valid pixels only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ys_q  <= '0;
            rcr_q <= '0;
            gcb_q <= '0;
            gcr_q <= '0;
            bcb_q <= '0;
        end else if (pix.de) begin
            ys_q  <= ys_d;
            rcr_q <= rcr_d;
            gcb_q <= gcb_d;
            gcr_q <= gcr_d;
            bcb_q <= bcb_d;
        end
    end

    // Stage 3: sum, scale down and saturate each channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else if (sync_q[0][2]) begin
            r_q <= clamp8(ys_q + rcr_q + RND);
            g_q <= clamp8(ys_q - gcb_q - gcr_q + RND);
            b_q <= clamp8(ys_q + bcb_q + RND);
        end
    end

    // Stage 4: pack to 565; holds the last pixel while de is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            rgb_q <= '0;
        else if (sync_q[1][2]) rgb_q <= {r_q[7:3], g_q[7:2], b_q[7:3]};
    end

    // Sync delay line behind the stage-1 register, matched to the data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SD; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {pix.de, pix.hs, pix.vs};
            for (int i = 1; i < SD; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign rgb_o.de    = sync_q[SD-1][2];
    assign rgb_o.hsync = sync_q[SD-1][1];
    assign rgb_o.vsync = sync_q[SD-1][0];
    assign rgb_o.data  = rgb_q;

endmodule

// File: tb/tb_ycbcr422_to_rgb565.sv
// Testbench for ycbcr422_to_rgb565: Cb-first and Cr-first instances on one stream.
// Table lines with fixed expectations, random lines against a reference model.
module tb_ycbcr422_to_rgb565;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ycbcr422_to_rgb565_if vin ();
    ycbcr422_to_rgb565_if out0 ();
    ycbcr422_to_rgb565_if out1 ();

    ycbcr422_to_rgb565 #(.CB_FIRST(1), .NEUTRAL_C(128)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ycbcr_i (vin),
        .rgb_o   (out0)
    );

    ycbcr422_to_rgb565 #(.CB_FIRST(0), .NEUTRAL_C(128)) u_dut_crf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ycbcr_i (vin),
        .rgb_o   (out1)
    );

    typedef struct {
        int          line;
        logic [7:0]  y;
        logic [7:0]  c;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] last0 = '0;
    logic [15:0] last1 = '0;
    logic [2:0]  hist[4] = '{default: 3'b000};
    logic [7:0]  ly[$];
    logic [7:0]  lc[$];
    logic [15:0] lx0[$];
    logic [15:0] lx1[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic int clip(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic logic [15:0] model(input int y, input int cb, input int cr);
        int r, g, b, rnd;
        rnd = 0;
`ifdef YCBCR2RGB_ROUND_EN
        rnd = 128;
`endif
        r = clip((256 * y + 359 * (cr - 128) + rnd) >>> 8);
        g = clip((256 * y - 88 * (cb - 128) - 183 * (cr - 128) + rnd) >>> 8);
        b = clip((256 * y + 454 * (cb - 128) + rnd) >>> 8);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    // Expected pixel i of the pending line: pairs (0,1),(2,3)...; lone last gets 128.
    function automatic logic [15:0] line_exp(input int i, input bit cbf);
        int c0, c1, n;
        n = ly.size();
        if (i % 2 == 0) begin
            c0 = int'(lc[i]);
            c1 = (i + 1 < n) ? int'(lc[i+1]) : 128;
        end else begin
            c0 = int'(lc[i-1]);
            c1 = int'(lc[i]);
        end
        return cbf ? model(int'(ly[i]), c0, c1) : model(int'(ly[i]), c1, c0);
    endfunction

    // Drive the pending line, push expectations, then gap de-low cycles.
    task automatic send_line(input int gap);
        logic [15:0] e0, e1;
        for (int i = 0; i < ly.size(); i++) begin
            e0 = line_exp(i, 1'b1);
            e1 = line_exp(i, 1'b0);
            if (i < lx0.size()) e0 = lx0[i];
            if (i < lx1.size()) e1 = lx1[i];
            vin.de    = 1'b1;
            vin.hsync = 1'b0;
            vin.vsync = 1'b0;
            vin.data  = {ly[i], lc[i]};
            q0.push_back(e0);
            q1.push_back(e1);
            @(posedge clk); #1;
        end
        for (int g = 0; g < gap; g++) begin
            vin.de    = 1'b0;
            vin.hsync = (g == 0);
            vin.vsync = 1'($urandom % 2);
            vin.data  = 16'($urandom);
            @(posedge clk); #1;
        end
        ly.delete();
        lc.delete();
        lx0.delete();
        lx1.delete();
    endtask

    // Reference for the sync delay: inputs seen at the last four edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist[i] <= 3'b000;
        end else begin
            hist[0] <= {vin.de, vin.hsync, vin.vsync};
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin : mon
        logic [15:0] e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            last0 = '0;
            last1 = '0;
        end
        check("sync0", 32'({out0.de, out0.hsync, out0.vsync}), 32'(hist[3]));
        check("sync1", 32'({out1.de, out1.hsync, out1.vsync}), 32'(hist[3]));
        if (out0.de) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_px0: got %h required no pixel", out0.data);
            end else begin
                e = q0.pop_front();
                check("px0", 32'(out0.data), 32'(e));
                last0 = e;
            end
        end else begin
            check("hold0", 32'(out0.data), 32'(last0));
        end
        if (out1.de) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_px1: got %h required no pixel", out1.data);
            end else begin
                e = q1.pop_front();
                check("px1", 32'(out1.data), 32'(e));
                last1 = e;
            end
        end else begin
            check("hold1", 32'(out1.data), 32'(last1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        vin.de    = 1'b0;
        vin.hsync = 1'b0;
        vin.vsync = 1'b0;
        vin.data  = '0;

        for (int i = 0; i < 8; i++) tbl.push_back('{1, 8'd128, 8'd128, 16'h8410});
        tbl.push_back('{2, 8'd255, 8'd128, 16'hFFFF});
        tbl.push_back('{2, 8'd255, 8'd128, 16'hFFFF});
        tbl.push_back('{2, 8'd0,   8'd128, 16'h0000});
        tbl.push_back('{2, 8'd0,   8'd128, 16'h0000});
        tbl.push_back('{3, 8'd76,  8'd85,  16'hF800});
        tbl.push_back('{3, 8'd76,  8'd255, 16'hF800});
        tbl.push_back('{4, 8'd255, 8'd128, 16'hFD3F});
        tbl.push_back('{4, 8'd255, 8'd255, 16'hFD3F});
        tbl.push_back('{5, 8'd128, 8'd200, 16'h833F});
        tbl.push_back('{5, 8'd128, 8'd128, 16'h833F});
        tbl.push_back('{5, 8'd128, 8'd128, 16'h8410});

        #2 rst_n = 1'b0;
        #1 check("reset0", 32'({out0.de, out0.hsync, out0.vsync, out0.data}), 32'd0);
        check("reset1", 32'({out1.de, out1.hsync, out1.vsync, out1.data}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            ly.push_back(tbl[i].y);
            lc.push_back(tbl[i].c);
            lx0.push_back(tbl[i].exp);
            if (i == tbl.size() - 1 || tbl[i+1].line != tbl[i].line) send_line(3);
        end

        for (int n = 0; n < 8; n++) begin
            int len;
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) begin
                ly.push_back(8'($urandom));
                lc.push_back(8'($urandom));
            end
            send_line($urandom_range(1, 3));
        end

        for (int i = 0; i < 6; i++) begin
            ly.push_back(8'(40 + 30 * i));
            lc.push_back(8'(20 + 40 * i));
        end
        send_line(0);
        #1 rst_n = 1'b0;
        #1 check("rst_mid0", 32'({out0.de, out0.hsync, out0.vsync, out0.data}), 32'd0);
        check("rst_mid1", 32'({out1.de, out1.hsync, out1.vsync, out1.data}), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ly.push_back(8'd76);
        lc.push_back(8'd255);
        ly.push_back(8'd76);
        lc.push_back(8'd85);
        lx1.push_back(16'hF800);
        lx1.push_back(16'hF800);
        send_line(3);

        for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) begin
            @(posedge clk);
        end
        check("drain0", 32'(q0.size()), 32'd0);
        check("drain1", 32'(q1.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
